// File: rtl/traffic_phase_sequencer.sv
// -----------------------------------------------------------------------------
// traffic_phase_sequencer
//
// Four-approach traffic-light phase sequencer. The approaches are served in
// the order N -> E -> S -> W, and each one runs GREEN -> YELLOW -> ALL_RED.
// The all-red hold is skipped when red_holding is 0. A prescaler derives a
// one-second tick from clk while mode_auto is high. In manual mode the
// countdown is frozen and the sequencer advances only on manual_next.
//
// Ports:
//   clk              system clock
//   rst              synchronous reset, active-high
//   mode_auto        1 = timed sequencing, 0 = manual stepping
//   manual_next      one-cycle pulse, advance one phase (manual mode only)
//   green_duration   green time in seconds (sampled at phase load)
//   yellow_duration  yellow time in seconds (sampled at phase load)
//   red_holding      all-red hold in seconds, 0 skips the hold
//   active_direction 00=N 01=E 10=S 11=W
//   phase            00=GREEN 01=YELLOW 10=ALL_RED
//   countdown_sec    seconds remaining in the current phase
//   lights           2 bits per approach, [7:6]=N .. [1:0]=W;
//                    00=red 01=yellow 10=green
//   second_tick      one-cycle pulse per elapsed second (auto mode)
// -----------------------------------------------------------------------------
module traffic_phase_sequencer #(
    parameter int TICK_DIV = 100000000,
    parameter int MAX_SEC  = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode_auto,
    input  logic       manual_next,
    input  logic [7:0] green_duration,
    input  logic [7:0] yellow_duration,
    input  logic [7:0] red_holding,
    output logic [1:0] active_direction,
    output logic [1:0] phase,
    output logic [7:0] countdown_sec,
    output logic [7:0] lights,
    output logic       second_tick
);

    localparam int                 PRESC_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [7:0]         MAX_SEC_B  = 8'(MAX_SEC);

    typedef enum logic [1:0] {
        ST_START   = 2'b00,
        ST_GREEN   = 2'b01,
        ST_YELLOW  = 2'b10,
        ST_ALL_RED = 2'b11
    } state_t;

    // Loaded durations are kept in 1..MAX_SEC. A loaded value of 0 would
    // otherwise produce a phase that never counts down.
    function automatic logic [7:0] clamp_dur(input logic [7:0] v);
        logic [7:0] r;
        if (v == 8'd0) begin
            r = 8'd1;
        end else if (v > MAX_SEC_B) begin
            r = MAX_SEC_B;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Map an internal state to the external phase code. START reports GREEN.
    function automatic logic [1:0] phase_code(input state_t s);
        logic [1:0] r;
        case (s)
            ST_YELLOW:  r = 2'b01;
            ST_ALL_RED: r = 2'b10;
            default:    r = 2'b00;
        endcase
        return r;
    endfunction

    // Build the lamp vector. Only the active approach can be non-red.
    function automatic logic [7:0] lamp_map(input state_t s, input logic [1:0] d);
        logic [1:0] c;
        logic [7:0] m;
        case (s)
            ST_GREEN:  c = 2'b10;
            ST_YELLOW: c = 2'b01;
            default:   c = 2'b00;
        endcase
        m = 8'h00;
        case (d)
            2'b00:   m[7:6] = c;
            2'b01:   m[5:4] = c;
            2'b10:   m[3:2] = c;
            2'b11:   m[1:0] = c;
            default: m = 8'h00;
        endcase
        return m;
    endfunction

    state_t             state_r,  state_s;
    logic [1:0]         dir_r,    dir_s;
    logic [7:0]         cnt_r,    cnt_s;
    logic [PRESC_W-1:0] presc_r,  presc_s;
    logic               tick_r,   tick_s;
    logic [1:0]         phase_r,  phase_s;
    logic [7:0]         lights_r, lights_s;

    state_t             succ_state_s;
    logic [1:0]         succ_dir_s;
    logic [7:0]         succ_cnt_s;
    logic               advance_s;

    // Next-state and next-output logic. The phase successor is computed first,
    // and then either the timer or manual_next decides whether it is taken.
    always_comb begin
        succ_state_s = ST_GREEN;
        succ_dir_s   = dir_r + 2'd1;
        succ_cnt_s   = clamp_dur(green_duration);
        case (state_r)
            ST_GREEN: begin
                succ_state_s = ST_YELLOW;
                succ_dir_s   = dir_r;
                succ_cnt_s   = clamp_dur(yellow_duration);
            end
            ST_YELLOW: begin
                if (red_holding != 8'd0) begin
                    succ_state_s = ST_ALL_RED;
                    succ_dir_s   = dir_r;
                    succ_cnt_s   = clamp_dur(red_holding);
                end else begin
                    succ_state_s = ST_GREEN;
                    succ_dir_s   = dir_r + 2'd1;
                    succ_cnt_s   = clamp_dur(green_duration);
                end
            end
            default: begin
                succ_state_s = ST_GREEN;
                succ_dir_s   = dir_r + 2'd1;
                succ_cnt_s   = clamp_dur(green_duration);
            end
        endcase

        state_s   = state_r;
        dir_s     = dir_r;
        cnt_s     = cnt_r;
        presc_s   = presc_r;
        tick_s    = 1'b0;
        advance_s = 1'b0;

        if (state_r == ST_START) begin
            // START always lasts one cycle, and then the N green is loaded.
            state_s = ST_GREEN;
            dir_s   = 2'b00;
            cnt_s   = clamp_dur(green_duration);
            presc_s = '0;
        end else begin
            if (mode_auto) begin
                if (presc_r == PRESC_LAST) begin
                    presc_s = '0;
                    tick_s  = 1'b1;
                    if (cnt_r > 8'd1) begin
                        cnt_s = cnt_r - 8'd1;
                    end else begin
                        advance_s = 1'b1;
                    end
                end else begin
                    presc_s = presc_r + PRESC_W'(1);
                end
            end else begin
                // Manual mode holds the prescaler at 0, so the first tick
                // after a return to auto comes a full second later.
                presc_s   = '0;
                advance_s = manual_next;
            end

            if (advance_s) begin
                state_s = succ_state_s;
                dir_s   = succ_dir_s;
                cnt_s   = succ_cnt_s;
                presc_s = '0;
            end else begin
                state_s = state_r;
            end
        end

        phase_s = phase_code(state_s);
        if (state_s == ST_START) begin
            lights_s = 8'h00;
        end else begin
            lights_s = lamp_map(state_s, dir_s);
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_START;
            dir_r    <= 2'b00;
            cnt_r    <= 8'd0;
            presc_r  <= '0;
            tick_r   <= 1'b0;
            phase_r  <= 2'b00;
            lights_r <= 8'h00;
        end else begin
            state_r  <= state_s;
            dir_r    <= dir_s;
            cnt_r    <= cnt_s;
            presc_r  <= presc_s;
            tick_r   <= tick_s;
            phase_r  <= phase_s;
            lights_r <= lights_s;
        end
    end

    assign active_direction = dir_r;
    assign phase            = phase_r;
    assign countdown_sec    = cnt_r;
    assign lights           = lights_r;
    assign second_tick      = tick_r;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_traffic_phase_sequencer
//
// Scoreboard bench. At each falling edge the driver applies inputs. A
// reference model then works out what the outputs must be after the coming
// rising edge, and that expectation is pushed into a queue. The monitor pops
// one entry after every rising edge and compares it against the DUT outputs.
// -----------------------------------------------------------------------------
module tb_traffic_phase_sequencer;

    localparam int TICK_DIV = 4;
    localparam int MAX_SEC  = 99;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode_auto;
    logic       manual_next;
    logic [7:0] green_duration;
    logic [7:0] yellow_duration;
    logic [7:0] red_holding;
    logic [1:0] active_direction;
    logic [1:0] phase;
    logic [7:0] countdown_sec;
    logic [7:0] lights;
    logic       second_tick;

    traffic_phase_sequencer #(.TICK_DIV(TICK_DIV), .MAX_SEC(MAX_SEC)) dut (
        .clk              (clk),
        .rst              (rst),
        .mode_auto        (mode_auto),
        .manual_next      (manual_next),
        .green_duration   (green_duration),
        .yellow_duration  (yellow_duration),
        .red_holding      (red_holding),
        .active_direction (active_direction),
        .phase            (phase),
        .countdown_sec    (countdown_sec),
        .lights           (lights),
        .second_tick      (second_tick)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0] dir;
        logic [1:0] ph;
        logic [7:0] cd;
        logic [7:0] lights;
        logic       tick;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state. ph: 0=green 1=yellow 2=all-red.
    bit m_start = 1'b1;
    int m_dir   = 0;
    int m_ph    = 0;
    int m_cd    = 0;
    int m_acc   = 0;
    bit m_tick  = 1'b0;

    function automatic int clampv(input int v);
        if (v == 0) return 1;
        if (v > MAX_SEC) return MAX_SEC;
        return v;
    endfunction

    // Advance the model by one rising edge using the current inputs, then
    // queue the expected outputs.
    task automatic step();
        bit   adv;
        exp_t e;
        int   col;
        adv = 1'b0;
        if (rst) begin
            m_start = 1'b1; m_dir = 0; m_ph = 0; m_cd = 0; m_acc = 0; m_tick = 1'b0;
        end else if (m_start) begin
            m_start = 1'b0; m_dir = 0; m_ph = 0; m_cd = clampv(green_duration);
            m_acc = 0; m_tick = 1'b0;
        end else begin
            m_tick = 1'b0;
            if (mode_auto) begin
                m_acc++;
                if (m_acc == TICK_DIV) begin
                    m_acc  = 0;
                    m_tick = 1'b1;
                    if (m_cd > 1) m_cd--;
                    else adv = 1'b1;
                end
            end else begin
                m_acc = 0;
                adv   = manual_next;
            end
            if (adv) begin
                m_acc = 0;
                if (m_ph == 0) begin
                    m_ph = 1; m_cd = clampv(yellow_duration);
                end else if (m_ph == 1 && red_holding != 8'd0) begin
                    m_ph = 2; m_cd = clampv(red_holding);
                end else begin
                    m_dir = (m_dir + 1) % 4; m_ph = 0; m_cd = clampv(green_duration);
                end
            end
        end
        e.dir    = 2'(m_dir);
        e.ph     = 2'(m_ph);
        e.cd     = 8'(m_cd);
        e.tick   = m_tick;
        e.lights = 8'h00;
        for (int a = 0; a < 4; a++) begin
            col = 0;
            if (!m_start && a == m_dir) col = (m_ph == 0) ? 2 : ((m_ph == 1) ? 1 : 0);
            e.lights[7 - 2*a -: 2] = 2'(col);
        end
        exp_q.push_back(e);
    endtask

    task automatic run(input int n);
        repeat (n) begin
            step();
            @(negedge clk);
        end
    endtask

    task automatic chk(input string name, input int act, input int expv);
        n_cmp++;
        if (act != expv) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
        end
    endtask

    // Monitor: compare every presented output cycle against the scoreboard.
    always @(posedge clk) begin
        exp_t e;
        int   nz;
        #1;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("active_direction", int'(active_direction), int'(e.dir));
            chk("phase",            int'(phase),            int'(e.ph));
            chk("countdown_sec",    int'(countdown_sec),    int'(e.cd));
            chk("lights",           int'(lights),           int'(e.lights));
            chk("second_tick",      int'(second_tick),      int'(e.tick));
            nz = 0;
            for (int a = 0; a < 4; a++) begin
                if (lights[2*a +: 2] != 2'b00) nz++;
            end
            chk("one_non_red", int'(nz <= 1), 1);
        end
    end

    initial begin
        rst = 1'b1; mode_auto = 1'b1; manual_next = 1'b0;
        green_duration = 8'd3; yellow_duration = 8'd2; red_holding = 8'd1;
        @(negedge clk);
        run(2);
        rst = 1'b0;
        run(40);

        // Full rotation with short phases.
        green_duration = 8'd2; yellow_duration = 8'd1; red_holding = 8'd1;
        run(300);

        // Clamping and skipping the all-red hold.
        green_duration = 8'd150; yellow_duration = 8'd0; red_holding = 8'd0;
        run(850);

        // Change green mid-phase.
        green_duration = 8'd5; yellow_duration = 8'd1; red_holding = 8'd1;
        for (int i = 0; i < 600 && !(m_ph == 0 && m_cd == 4); i++) run(1);
        green_duration = 8'd9;
        run(200);

        // Manual mode: frozen countdown, step, then resume.
        green_duration = 8'd6;
        for (int i = 0; i < 600 && !(m_ph == 0 && m_cd == 4 && m_acc == 0); i++) run(1);
        mode_auto = 1'b0;
        run(40);
        manual_next = 1'b1;
        run(1);
        manual_next = 1'b0;
        run(10);
        mode_auto = 1'b1;
        run(20);

        // Reset during E yellow with countdown 2.
        green_duration = 8'd2; yellow_duration = 8'd3; red_holding = 8'd1;
        for (int i = 0; i < 600 && !(!m_start && m_dir == 1 && m_ph == 1 && m_cd == 2); i++) run(1);
        rst = 1'b1;
        run(1);
        rst = 1'b0;
        run(20);

        // Randomised traffic, including manual pulses that arrive while in auto mode.
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 49) == 0) mode_auto = ~mode_auto;
            manual_next = ($urandom_range(0, 11) == 0);
            if ($urandom_range(0, 19) == 0) green_duration  = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 19) == 0) yellow_duration = 8'($urandom_range(0, 4));
            if ($urandom_range(0, 19) == 0) red_holding     = 8'($urandom_range(0, 3));
            rst = ($urandom_range(0, 199) == 0);
            run(1);
        end
        rst = 1'b0; manual_next = 1'b0;
        run(4);

        repeat (3) @(posedge clk);
        #2;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
